// File: rtl/spi_frame_controller.sv
// spi_frame_controller: decodes SPI command bytes, streams a frame into the pixel
// buffer and sequences the edge-detection kernel, reporting busy/loaded/error status.
module spi_frame_controller #(
   parameter int          IMG_W    = 8,
   parameter int          IMG_H    = 8,
   parameter int          ADDR_W   = $clog2(IMG_W*IMG_H),
   parameter logic [7:0]  CMD_LOAD = 8'hA5,
   parameter logic [7:0]  CMD_RUN  = 8'h5A
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              csActive,
   input  logic [7:0]        rxData,
   input  logic              rxValid,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [7:0]        memData,
   output logic              kernelStart,
   input  logic              kernelDone,
   output logic              busy,
   output logic              frameLoaded,
   output logic              frameDone,
   output logic              errPulse
);
   localparam int PIXELS = IMG_W*IMG_H;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIXELS-1);

   typedef enum logic [1:0] {IDLE, LOAD, START, RUN} state_t;
   state_t state, state_n;
   logic [ADDR_W-1:0] cnt, cnt_n, addr_n;
   logic [7:0] data_n;
   logic cs_q, cs_fall, we_n, ks_n, fl_n, fd_n, err_n;

   assign cs_fall = cs_q & ~csActive;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      fl_n    = frameLoaded;
      addr_n  = memAddr;
      data_n  = memData;
      we_n    = 1'b0;
      fd_n    = 1'b0;
      err_n   = 1'b0;
      case (state)
         IDLE:
            if (rxValid) begin
               if (rxData == CMD_LOAD) begin
                  cnt_n   = '0;
                  fl_n    = 1'b0;
                  state_n = LOAD;
               end else if (rxData == CMD_RUN && frameLoaded)
                  state_n = START;
               else
                  err_n = 1'b1;
            end
         LOAD:
            // an abort beats a byte arriving in the same cycle, even the last pixel
            if (cs_fall) begin
               err_n   = 1'b1;
               cnt_n   = '0;
               state_n = IDLE;
            end else if (rxValid) begin
               we_n   = 1'b1;
               addr_n = cnt;
               data_n = rxData;
               if (cnt == LAST) begin
                  fl_n    = 1'b1;
                  cnt_n   = '0;
                  state_n = IDLE;
               end else
                  cnt_n = cnt + 1'b1;
            end
         START: begin
            err_n   = rxValid;
            state_n = RUN;
         end
         RUN: begin
            err_n = rxValid;
            if (kernelDone) begin
               fd_n    = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      ks_n = (state_n == START);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         cs_q        <= 1'b0;
         memWe       <= 1'b0;
         memAddr     <= '0;
         memData     <= '0;
         kernelStart <= 1'b0;
         busy        <= 1'b0;
         frameLoaded <= 1'b0;
         frameDone   <= 1'b0;
         errPulse    <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         cs_q        <= csActive;
         memWe       <= we_n;
         memAddr     <= addr_n;
         memData     <= data_n;
         kernelStart <= ks_n;
         busy        <= (state_n != IDLE);
         frameLoaded <= fl_n;
         frameDone   <= fd_n;
         errPulse    <= err_n;
      end
endmodule

// File: tb/tb_spi_frame_controller.sv
// tb_spi_frame_controller: randomized frame load / kernel run / abort / reset scenarios
// checked against a transaction-level model of expected writes and pulse counts.
module tb_spi_frame_controller;
   localparam int PIX = 64;
   localparam logic [7:0] LD = 8'hA5, RN = 8'h5A;

   logic clk = 0, rst = 1, csActive = 0, rxValid = 0, kernelDone = 0;
   logic [7:0] rxData = 0;
   logic memWe, kernelStart, busy, frameLoaded, frameDone, errPulse;
   logic [5:0] memAddr;
   logic [7:0] memData;

   spi_frame_controller dut (
      .clk(clk), .rst(rst), .csActive(csActive), .rxData(rxData), .rxValid(rxValid),
      .memWe(memWe), .memAddr(memAddr), .memData(memData), .kernelStart(kernelStart),
      .kernelDone(kernelDone), .busy(busy), .frameLoaded(frameLoaded),
      .frameDone(frameDone), .errPulse(errPulse)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int we_cnt = 0, ks_cnt = 0, fd_cnt = 0, err_cnt = 0;
   int b_we, b_ks, b_fd, b_err;
   logic [5:0] wa_q[$];
   logic [7:0] wd_q[$];
   logic [7:0] px[PIX];

   always @(negedge clk) begin
      if (memWe) begin
         we_cnt++;
         wa_q.push_back(memAddr);
         wd_q.push_back(memData);
      end
      if (kernelStart) ks_cnt++;
      if (frameDone) fd_cnt++;
      if (errPulse) err_cnt++;
   end

   task automatic mark();
      b_we = we_cnt; b_ks = ks_cnt; b_fd = fd_cnt; b_err = err_cnt;
      wa_q.delete(); wd_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input bit drop_cs = 0);
      @(posedge clk); #1 rxData = b; rxValid = 1;
      if (drop_cs) csActive = 0;
      @(posedge clk); #1 rxValid = 0;
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) @(posedge clk);
   endtask

   task automatic kick_done();
      @(posedge clk); #1 kernelDone = 1;
      @(posedge clk); #1 kernelDone = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({memWe, memAddr, memData, kernelStart, busy, frameLoaded, frameDone, errPulse} !== '0) begin
         errors++; $display("FAIL reset_outputs: got %b want all zero",
            {memWe, memAddr, memData, kernelStart, busy, frameLoaded, frameDone, errPulse});
      end
      rst = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, frameLoaded, errPulse} !== 3'b000) begin
         errors++; $display("FAIL reset_idle: busy/loaded/err=%b want 000", {busy, frameLoaded, errPulse});
      end
   endtask

   task automatic test_err_idle();
      logic [7:0] b;
      mark();
      send_byte(RN); gap();
      send_byte(8'h33); gap();
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         while (b == LD || b == RN) b = 8'($urandom);
         send_byte(b);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (err_cnt - b_err !== 5) begin
         errors++; $display("FAIL idle_err_count: got %0d want 5", err_cnt - b_err);
      end
      checks++;
      if (ks_cnt - b_ks !== 0 || busy !== 1'b0 || we_cnt - b_we !== 0) begin
         errors++; $display("FAIL idle_no_action: ks=%0d busy=%b we=%0d want 0 0 0",
            ks_cnt - b_ks, busy, we_cnt - b_we);
      end
   endtask

   task automatic check_writes(input string tag, input int n);
      checks++;
      if (wa_q.size() !== n) begin
         errors++; $display("FAIL %s_write_count: got %0d want %0d", tag, wa_q.size(), n);
      end
      for (int i = 0; i < n && i < wa_q.size(); i++) begin
         checks++;
         if (wa_q[i] !== 6'(i) || wd_q[i] !== px[i]) begin
            errors++; $display("FAIL %s_write[%0d]: addr=%0d data=%h want addr=%0d data=%h",
               tag, i, wa_q[i], wd_q[i], i, px[i]);
         end
      end
   endtask

   task automatic test_load(input bit seq);
      for (int i = 0; i < PIX; i++) px[i] = seq ? 8'(i) : 8'($urandom);
      mark();
      csActive = 1;
      send_byte(LD); gap();
      for (int i = 0; i < PIX; i++) begin
         send_byte(px[i]);
         if (i != PIX - 1) begin
            checks++;
            if (busy !== 1'b1 || frameLoaded !== 1'b0) begin
               errors++; $display("FAIL load_busy[%0d]: busy=%b loaded=%b want 1 0", i, busy, frameLoaded);
            end
            gap();
         end
      end
      @(negedge clk);
      checks++;
      if (memWe !== 1'b1 || memAddr !== 6'd63 || frameLoaded !== 1'b1) begin
         errors++; $display("FAIL load_final: we=%b addr=%0d loaded=%b want 1 63 1", memWe, memAddr, frameLoaded);
      end
      @(negedge clk);
      checks++;
      if (memWe !== 1'b0 || busy !== 1'b0 || frameLoaded !== 1'b1 || err_cnt - b_err !== 0) begin
         errors++; $display("FAIL load_after: we=%b busy=%b loaded=%b err=%0d want 0 0 1 0",
            memWe, busy, frameLoaded, err_cnt - b_err);
      end
      check_writes("load", PIX);
   endtask

   task automatic test_run(input int nbytes);
      bit found = 0, busy_ok = 1;
      mark();
      send_byte(RN);
      for (int i = 0; i < 8 && !found; i++) begin
         @(negedge clk);
         if (kernelStart) found = 1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL run_start_seen: kernelStart=0 want 1 within 8 cycles");
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         rxValid = (i < nbytes);
         rxData  = 8'($urandom);
         @(negedge clk);
         if (!busy) busy_ok = 0;
      end
      @(posedge clk); #1 rxValid = 0;
      kick_done();
      repeat (3) @(negedge clk);
      checks++;
      if (!busy_ok) begin
         errors++; $display("FAIL run_busy: busy dropped=1 want 0");
      end
      checks++;
      if (ks_cnt - b_ks !== 1 || fd_cnt - b_fd !== 1) begin
         errors++; $display("FAIL run_pulses: ks=%0d fd=%0d want 1 1", ks_cnt - b_ks, fd_cnt - b_fd);
      end
      checks++;
      if (err_cnt - b_err !== nbytes || we_cnt - b_we !== 0) begin
         errors++; $display("FAIL run_rx_drop: err=%0d we=%0d want %0d 0", err_cnt - b_err, we_cnt - b_we, nbytes);
      end
      checks++;
      if (frameLoaded !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL run_after: loaded=%b busy=%b want 1 0", frameLoaded, busy);
      end
   endtask

   task automatic test_abort(input int k);
      for (int i = 0; i < PIX; i++) px[i] = 8'($urandom);
      mark();
      csActive = 1;
      send_byte(LD); gap();
      for (int i = 0; i < k; i++) begin
         send_byte(px[i]); gap();
      end
      send_byte(px[k], 1);
      repeat (3) @(negedge clk);
      checks++;
      if (err_cnt - b_err !== 1 || frameLoaded !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL abort_%0d_status: err=%0d loaded=%b busy=%b want 1 0 0",
            k, err_cnt - b_err, frameLoaded, busy);
      end
      check_writes("abort", k);
   endtask

   task automatic test_reset_mid_load();
      for (int i = 0; i < PIX; i++) px[i] = 8'($urandom);
      mark();
      csActive = 1;
      send_byte(LD);
      for (int i = 0; i <= 30; i++) send_byte(px[i]);
      #1 rst = 1;
      #1;
      checks++;
      if ({memWe, memAddr, memData, kernelStart, busy, frameLoaded, frameDone, errPulse} !== '0) begin
         errors++; $display("FAIL rst_load_outputs: got %b want all zero",
            {memWe, memAddr, memData, kernelStart, busy, frameLoaded, frameDone, errPulse});
      end
      repeat (2) @(posedge clk);
      #1 rst = 0;
      mark();
      repeat (5) @(negedge clk);
      send_byte(RN);
      repeat (3) @(negedge clk);
      checks++;
      if (err_cnt - b_err !== 1 || ks_cnt - b_ks !== 0 || fd_cnt - b_fd !== 0 || we_cnt - b_we !== 0) begin
         errors++; $display("FAIL rst_load_after: err=%0d ks=%0d fd=%0d we=%0d want 1 0 0 0",
            err_cnt - b_err, ks_cnt - b_ks, fd_cnt - b_fd, we_cnt - b_we);
      end
   endtask

   task automatic test_reset_mid_run();
      bit found = 0;
      test_load(0);
      send_byte(RN);
      for (int i = 0; i < 8 && !found; i++) begin
         @(negedge clk);
         if (kernelStart) found = 1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL rst_run_start: kernelStart=0 want 1 within 8 cycles");
      end
      repeat (3) @(posedge clk);
      #1 rst = 1;
      #1;
      checks++;
      if ({memWe, memAddr, memData, kernelStart, busy, frameLoaded, frameDone, errPulse} !== '0) begin
         errors++; $display("FAIL rst_run_outputs: got %b want all zero",
            {memWe, memAddr, memData, kernelStart, busy, frameLoaded, frameDone, errPulse});
      end
      repeat (2) @(posedge clk);
      #1 rst = 0;
      mark();
      kick_done();
      repeat (3) @(negedge clk);
      send_byte(RN);
      repeat (3) @(negedge clk);
      checks++;
      if (fd_cnt - b_fd !== 0 || ks_cnt - b_ks !== 0 || err_cnt - b_err !== 1 || busy !== 1'b0) begin
         errors++; $display("FAIL rst_run_after: fd=%0d ks=%0d err=%0d busy=%b want 0 0 1 0",
            fd_cnt - b_fd, ks_cnt - b_ks, err_cnt - b_err, busy);
      end
   endtask

   initial begin
      test_reset();
      test_err_idle();
      test_load(1);
      test_run(0);
      test_run(0);
      test_run(3);
      test_abort(20);
      test_load(0);
      test_abort(63);
      test_load(0);
      test_run(8);
      test_reset_mid_load();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation still running at 2ms want finished");
      $fatal(1);
   end
endmodule
